// File: rtl/spi_slave_dev_if.sv
// Bus bundle for the SPI slave device: the serial pins toward the SPI master
// and the parallel word/status interface toward the local host logic.
interface spi_slave_dev_if;
  logic        sclk_i;
  logic        mosi_i;
  logic        cs_i;
  logic        miso_o;
  logic [31:0] data_rx_bo;
  logic        data_rx_wr_o;
  logic [31:0] data_tx_bi;
  logic        data_tx_wr_i;
  logic        busy_o;
  logic        tx_empty_o;
  logic        underrun_o;
  logic        frame_err_o;

  // Seen from the slave device itself
  modport slave (
    input  sclk_i, mosi_i, cs_i, data_tx_bi, data_tx_wr_i,
    output miso_o, data_rx_bo, data_rx_wr_o, busy_o, tx_empty_o,
           underrun_o, frame_err_o
  );

  // Seen from whatever drives the device (SPI master plus host)
  modport master (
    output sclk_i, mosi_i, cs_i, data_tx_bi, data_tx_wr_i,
    input  miso_o, data_rx_bo, data_rx_wr_o, busy_o, tx_empty_o,
           underrun_o, frame_err_o
  );
endinterface

// File: rtl/spi_slave_dev.sv
// SPI mode-0 slave, MSB first, 32-bit words. The SPI pins are oversampled
// by clk_i through synchronizer chains; all edges are found by comparing the
// synchronized value with its copy from the previous cycle. A single TX
// holding register feeds the shift register at frame start and again after
// every completed word, so words can stream back-to-back under one cs low.
module spi_slave_dev #(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  spi_slave_dev_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_bit_cnt;
  logic [31:0] r_rx_shift;
  logic [31:0] r_rx_data;
  logic        r_rx_wr;
  logic        r_frame_err;
  logic [31:0] r_tx_shift;
  logic [31:0] r_tx_hold;
  logic        r_tx_full;
  logic        r_underrun;
  logic        r_reload_pend;

  logic        w_sclk_s, w_mosi_s, w_cs_s;
  logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  logic        w_start, w_end, w_rise, w_fall, w_tx_load;
  logic [31:0] w_tx_load_val;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_cs_fall   = ~w_cs_s & r_cs_prev;
  assign w_cs_rise   = w_cs_s & ~r_cs_prev;

  // Synchronize the SPI pins and keep previous-cycle copies for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_i};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and per-cycle control strobes; cs rising wins over any sclk edge
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_end         = 1'b0;
    w_rise        = 1'b0;
    w_fall        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_start      = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_end        = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_rise = w_sclk_rise;
          w_fall = w_sclk_fall;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_tx_load     = w_start | (w_fall & r_reload_pend);
    w_tx_load_val = r_tx_full ? r_tx_hold : 32'h0;
  end

  // Receive path: bit counter, RX shift register, completed-word output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_wr     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_wr     <= 1'b0;
      r_frame_err <= w_end && (r_bit_cnt != 5'd0);
      if (w_start) begin
        r_bit_cnt <= '0;
      end else if (w_rise) begin
        r_rx_shift <= {r_rx_shift[30:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + 5'd1;
        if (r_bit_cnt == 5'd31) begin
          r_rx_data <= {r_rx_shift[30:0], w_mosi_s};
          r_rx_wr   <= 1'b1;
        end
      end
    end
  end

  // Transmit path: shift on sclk falling, reload at frame start and after each word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_shift    <= '0;
      r_reload_pend <= 1'b0;
    end else begin
      if (w_tx_load)     r_tx_shift <= w_tx_load_val;
      else if (w_fall)   r_tx_shift <= {r_tx_shift[30:0], 1'b0};
      if (w_tx_load)     r_reload_pend <= 1'b0;
      else if (w_rise && r_bit_cnt == 5'd31) r_reload_pend <= 1'b1;
    end
  end

  // Holding register and underrun flag; a host write wins over a coincident load
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_hold  <= '0;
      r_tx_full  <= 1'b0;
      r_underrun <= 1'b0;
    end else if (bus.data_tx_wr_i) begin
      r_tx_hold  <= bus.data_tx_bi;
      r_tx_full  <= 1'b1;
      r_underrun <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_full <= 1'b0;
      if (!r_tx_full) r_underrun <= 1'b1;
    end
  end

  assign bus.miso_o       = (r_state == ST_SHIFT) & r_tx_shift[31];
  assign bus.data_rx_bo   = r_rx_data;
  assign bus.data_rx_wr_o = r_rx_wr;
  assign bus.busy_o       = (r_state == ST_SHIFT);
  assign bus.tx_empty_o   = ~r_tx_full;
  assign bus.underrun_o   = r_underrun;
  assign bus.frame_err_o  = r_frame_err;

endmodule

// File: tb/tb_spi_slave_dev.sv
// Directed bench for spi_slave_dev: a bit-banged SPI master in mode 0 with
// expected RX words and expected MISO words held in scoreboard queues.
module tb_spi_slave_dev;
  localparam int SYNC = 2;
  localparam int HALF = 8;  // sclk half period in clk cycles

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_dev_if bus();

  spi_slave_dev #(.SYNC_STAGES(SYNC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_ferr = 0;
  int s0, f0;
  logic [31:0] exp_rx_q[$];
  logic [31:0] exp_tx_q[$];
  logic [31:0] miso_cap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [31:0] d);
    bus.data_tx_bi   = d;
    bus.data_tx_wr_i = 1'b1;
    cyc(1);
    bus.data_tx_wr_i = 1'b0;
  endtask

  // Shift nbits MSB first; optionally pulse a host write during bit wr_bit's low phase
  task automatic xfer(input logic [31:0] mosi_w, input int nbits, input int wr_bit,
                      input logic [31:0] wr_data, output logic [31:0] miso_w);
    miso_w = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi_i = mosi_w[31-i];
      if (i == wr_bit) begin
        write_tx(wr_data);
        cyc(HALF - 1);
      end else begin
        cyc(HALF);
      end
      miso_w[31-i] = bus.miso_o;
      bus.sclk_i = 1'b1;
      cyc(HALF);
      bus.sclk_i = 1'b0;
    end
  endtask

  task automatic word(input logic [31:0] mosi_w, input int wr_bit, input logic [31:0] wr_data);
    logic [31:0] exp_w;
    xfer(mosi_w, 32, wr_bit, wr_data, miso_cap);
    exp_w = exp_tx_q.pop_front();
    $display("word: mosi %h miso %h expected miso %h", mosi_w, miso_cap, exp_w);
    check("miso_word", miso_cap, exp_w);
  endtask

  task automatic cs_low();
    bus.cs_i = 1'b0;
    cyc(HALF);
  endtask

  task automatic cs_high();
    cyc(HALF);
    bus.cs_i = 1'b1;
    cyc(HALF);
  endtask

  // Receive monitor: every strobe must match the oldest expected word
  always @(negedge clk) begin
    if (bus.frame_err_o === 1'b1) n_ferr++;
    if (bus.data_rx_wr_o === 1'b1) begin
      n_strobe++;
      check("strobe_expected", 32'(exp_rx_q.size() != 0), 32'd1);
      if (exp_rx_q.size() != 0) begin
        logic [31:0] e;
        e = exp_rx_q.pop_front();
        $display("rx strobe: data_rx_bo %h expected %h", bus.data_rx_bo, e);
        check("rx_word", bus.data_rx_bo, e);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.sclk_i = 1'b0;
    bus.mosi_i = 1'b0;
    bus.cs_i = 1'b1;
    bus.data_tx_bi = '0;
    bus.data_tx_wr_i = 1'b0;
    cyc(3);
    check("rst_miso",      bus.miso_o,       0);
    check("rst_rx_data",   bus.data_rx_bo,   0);
    check("rst_rx_wr",     bus.data_rx_wr_o, 0);
    check("rst_busy",      bus.busy_o,       0);
    check("rst_tx_empty",  bus.tx_empty_o,   1);
    check("rst_underrun",  bus.underrun_o,   0);
    check("rst_frame_err", bus.frame_err_o,  0);
    rst = 1'b0;
    cyc(2);

    // Single word: A5A50F0F out, 12345678 in
    write_tx(32'hA5A5_0F0F);
    check("t1_tx_full", bus.tx_empty_o, 0);
    exp_tx_q.push_back(32'hA5A5_0F0F);
    exp_rx_q.push_back(32'h1234_5678);
    cs_low();
    check("t1_busy", bus.busy_o, 1);
    check("t1_tx_empty_after_load", bus.tx_empty_o, 1);
    word(32'h1234_5678, -1, '0);
    cs_high();
    check("t1_busy_end", bus.busy_o, 0);
    check("t1_strobes", n_strobe, 1);
    check("t1_rx_hold", bus.data_rx_bo, 32'h1234_5678);
    check("t1_tx_empty", bus.tx_empty_o, 1);
    check("t1_miso_idle", bus.miso_o, 0);

    // Back-to-back words, holding rewritten with DEADBEEF during the first
    write_tx(32'h0F1E_2D3C);
    exp_tx_q.push_back(32'h0F1E_2D3C);
    exp_tx_q.push_back(32'hDEAD_BEEF);
    exp_rx_q.push_back(32'h89AB_CDEF);
    exp_rx_q.push_back(32'h1357_9BDF);
    cs_low();
    word(32'h89AB_CDEF, 10, 32'hDEAD_BEEF);
    check("t2_busy_mid", bus.busy_o, 1);
    word(32'h1357_9BDF, -1, '0);
    cs_high();
    check("t2_strobes", n_strobe, 3);
    check("t2_ferr", n_ferr, 0);

    // Frame with empty holding register: zeros out, sticky underrun
    exp_tx_q.push_back(32'h0);
    exp_rx_q.push_back(32'hFFFF_0000);
    cs_low();
    check("t3_underrun_start", bus.underrun_o, 1);
    word(32'hFFFF_0000, -1, '0);
    cs_high();
    check("t3_underrun_sticky", bus.underrun_o, 1);
    write_tx(32'h1111_1111);
    check("t3_underrun_cleared", bus.underrun_o, 0);
    check("t3_tx_full", bus.tx_empty_o, 0);

    // Host write in the same cycle as the frame-start load
    bus.cs_i = 1'b0;
    cyc(SYNC);
    write_tx(32'h2222_2222);
    cyc(HALF - SYNC - 1);
    check("t4_busy", bus.busy_o, 1);
    check("t4_tx_full", bus.tx_empty_o, 0);
    exp_tx_q.push_back(32'h1111_1111);
    exp_rx_q.push_back(32'h2468_ACE0);
    word(32'h2468_ACE0, -1, '0);
    cs_high();
    check("t4_strobes", n_strobe, 5);

    // cs released after 17 bits: frame error, partial word dropped
    s0 = n_strobe;
    f0 = n_ferr;
    cs_low();
    xfer(32'hFEDC_BA98, 17, -1, '0, miso_cap);
    cs_high();
    cyc(4);
    check("t5_ferr_pulses", n_ferr - f0, 1);
    check("t5_no_strobe", n_strobe - s0, 0);
    check("t5_rx_unchanged", bus.data_rx_bo, 32'h2468_ACE0);
    check("t5_busy", bus.busy_o, 0);

    // Reset mid-frame, then a clean frame carrying 00000001
    f0 = n_ferr;
    s0 = n_strobe;
    cs_low();
    xfer(32'hFFFF_FFFF, 10, -1, '0, miso_cap);
    rst = 1'b1;
    bus.cs_i = 1'b1;
    cyc(3);
    check("t6_rst_rx", bus.data_rx_bo, 0);
    check("t6_rst_busy", bus.busy_o, 0);
    check("t6_rst_tx_empty", bus.tx_empty_o, 1);
    check("t6_rst_miso", bus.miso_o, 0);
    rst = 1'b0;
    cyc(HALF);
    check("t6_no_strobe_on_abort", n_strobe - s0, 0);
    exp_tx_q.push_back(32'h0);
    exp_rx_q.push_back(32'h0000_0001);
    cs_low();
    word(32'h0000_0001, -1, '0);
    cs_high();
    check("t6_one_strobe", n_strobe - s0, 1);
    check("t6_no_ferr", n_ferr - f0, 0);
    check("t6_rx", bus.data_rx_bo, 32'h0000_0001);
    check("t6_underrun", bus.underrun_o, 1);
    check("t6_rx_queue_drained", exp_rx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
